// File: rtl/hasti_arbiter.sv
// hasti_arbiter
//   Shares one AHB-lite (HASTI) slave port between two masters. Address and
//   control of the granted master pass straight through to the slave; write
//   data follows the registered data-phase owner. A master whose data phase
//   completes while its next address phase is held off gets its response
//   buffered and delivered when that address phase is finally accepted.
//
// Parameters
//   RR        1 = round-robin between the masters, 0 = fixed priority (m0 wins)
// Ports
//   hclk, hresetn            bus clock, asynchronous active-low reset
//   m0_* / m1_*              master-side buses: haddr, hwrite, hsize, hburst,
//                            hmastlock, hprot, htrans, hwdata in;
//                            hrdata, hready, hresp out
//   s_*                      shared slave bus, same signals, directions reversed
module hasti_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic        hclk,
  input  logic        hresetn,
  // master 0
  input  logic [31:0] m0_haddr,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [2:0]  m0_hburst,
  input  logic        m0_hmastlock,
  input  logic [3:0]  m0_hprot,
  input  logic [1:0]  m0_htrans,
  input  logic [31:0] m0_hwdata,
  output logic [31:0] m0_hrdata,
  output logic        m0_hready,
  output logic        m0_hresp,
  // master 1
  input  logic [31:0] m1_haddr,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [2:0]  m1_hburst,
  input  logic        m1_hmastlock,
  input  logic [3:0]  m1_hprot,
  input  logic [1:0]  m1_htrans,
  input  logic [31:0] m1_hwdata,
  output logic [31:0] m1_hrdata,
  output logic        m1_hready,
  output logic        m1_hresp,
  // shared slave
  output logic [31:0] s_haddr,
  output logic        s_hwrite,
  output logic [2:0]  s_hsize,
  output logic [2:0]  s_hburst,
  output logic        s_hmastlock,
  output logic [3:0]  s_hprot,
  output logic [1:0]  s_htrans,
  output logic [31:0] s_hwdata,
  input  logic [31:0] s_hrdata,
  input  logic        s_hready,
  input  logic        s_hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_M0   = 2'd1,
    GNT_M1   = 2'd2
  } gnt_e;

  gnt_e        gnt_r, gnt_s;
  logic        last_r;      // 0 = m0, 1 = m1 (round-robin pointer)
  logic        downer_r;    // data-phase owner: 0 = m0, 1 = m1
  logic        dvalid_r;
  logic        pend0_r, pend1_r;
  logic        hold0_resp_r, hold1_resp_r;
  logic [31:0] hold0_r, hold1_r;

  logic        req0_s, req1_s, own0_s, own1_s, gnt0_s, gnt1_s, sel_m1_s;
  logic [1:0]  gnt_htrans_s;

  // hready seen by one master, before reset gating.
  function automatic logic slot_ready(input logic pend, input logic own,
                                      input logic req, input logic gnt,
                                      input logic s_rdy);
    logic rdy;
    if (pend) begin
      rdy = gnt & s_rdy;              // buffered response released on acceptance
    end else if (own) begin
      rdy = (req && !gnt) ? 1'b0 : s_rdy;
    end else if (req) begin
      rdy = gnt ? s_rdy : 1'b0;
    end else begin
      rdy = 1'b1;
    end
    return rdy;
  endfunction

  assign req0_s = m0_htrans[1];
  assign req1_s = m1_htrans[1];
  assign own0_s = dvalid_r & ~downer_r;
  assign own1_s = dvalid_r &  downer_r;
  assign gnt0_s = (gnt_s == GNT_M0);
  assign gnt1_s = (gnt_s == GNT_M1);

  // Arbitration: frozen while the slave stalls, bursts and locked owners keep the bus.
  always_comb begin
    gnt_s = GNT_NONE;
    if (!hresetn) begin
      gnt_s = GNT_NONE;
    end else if (!s_hready) begin
      gnt_s = gnt_r;
    end else if (gnt_r == GNT_M0 && m0_htrans == HTRANS_SEQ) begin
      gnt_s = GNT_M0;
    end else if (gnt_r == GNT_M1 && m1_htrans == HTRANS_SEQ) begin
      gnt_s = GNT_M1;
    end else if (own0_s && m0_hmastlock && req0_s) begin
      gnt_s = GNT_M0;
    end else if (own1_s && m1_hmastlock && req1_s) begin
      gnt_s = GNT_M1;
    end else if (req0_s && req1_s) begin
      if (RR && !last_r) begin
        gnt_s = GNT_M1;
      end else begin
        gnt_s = GNT_M0;
      end
    end else if (req0_s) begin
      gnt_s = GNT_M0;
    end else if (req1_s) begin
      gnt_s = GNT_M1;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  // Slave address/control mux; with no grant the idle cycle borrows the last master's fields.
  always_comb begin
    sel_m1_s = gnt1_s | ((gnt_s == GNT_NONE) & last_r);
    if (sel_m1_s) begin
      s_haddr     = m1_haddr;
      s_hwrite    = m1_hwrite;
      s_hsize     = m1_hsize;
      s_hburst    = m1_hburst;
      s_hmastlock = m1_hmastlock;
      s_hprot     = m1_hprot;
      gnt_htrans_s = m1_htrans;
    end else begin
      s_haddr     = m0_haddr;
      s_hwrite    = m0_hwrite;
      s_hsize     = m0_hsize;
      s_hburst    = m0_hburst;
      s_hmastlock = m0_hmastlock;
      s_hprot     = m0_hprot;
      gnt_htrans_s = m0_htrans;
    end
    if (gnt_s == GNT_NONE) begin
      s_htrans = HTRANS_IDLE;
    end else begin
      s_htrans = gnt_htrans_s;
    end
    if (!dvalid_r) begin
      s_hwdata = 32'h0;
    end else if (downer_r) begin
      s_hwdata = m1_hwdata;
    end else begin
      s_hwdata = m0_hwdata;
    end
  end

  // Master responses; forced to idle values while reset is asserted.
  always_comb begin
    m0_hready = 1'b1;
    m0_hresp  = 1'b0;
    m0_hrdata = 32'h0;
    m1_hready = 1'b1;
    m1_hresp  = 1'b0;
    m1_hrdata = 32'h0;
    if (hresetn) begin
      m0_hready = slot_ready(pend0_r, own0_s, req0_s, gnt0_s, s_hready);
      m0_hresp  = pend0_r ? hold0_resp_r : (own0_s ? s_hresp : 1'b0);
      m0_hrdata = pend0_r ? hold0_r : s_hrdata;
      m1_hready = slot_ready(pend1_r, own1_s, req1_s, gnt1_s, s_hready);
      m1_hresp  = pend1_r ? hold1_resp_r : (own1_s ? s_hresp : 1'b0);
      m1_hrdata = pend1_r ? hold1_r : s_hrdata;
    end else begin
      m0_hready = 1'b1;
      m1_hready = 1'b1;
    end
  end

  // Grant, data-phase owner and round-robin pointer.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      gnt_r    <= GNT_NONE;
      last_r   <= 1'b1;
      downer_r <= 1'b0;
      dvalid_r <= 1'b0;
    end else begin
      gnt_r <= gnt_s;
      if (s_hready) begin
        downer_r <= gnt1_s;
        dvalid_r <= (gnt_s != GNT_NONE) && (gnt_htrans_s != HTRANS_IDLE);
        if (gnt_s != GNT_NONE && gnt_htrans_s == HTRANS_NONSEQ) begin
          last_r <= gnt1_s;
        end else begin
          last_r <= last_r;
        end
      end else begin
        downer_r <= downer_r;
        dvalid_r <= dvalid_r;
      end
    end
  end

  // Response buffers: capture when an owner's data completes but its next address is held off.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pend0_r      <= 1'b0;
      pend1_r      <= 1'b0;
      hold0_r      <= 32'h0;
      hold1_r      <= 32'h0;
      hold0_resp_r <= 1'b0;
      hold1_resp_r <= 1'b0;
    end else begin
      if (pend0_r) begin
        pend0_r <= ~(gnt0_s & s_hready);
      end else if (s_hready && own0_s && req0_s && !gnt0_s) begin
        pend0_r      <= 1'b1;
        hold0_r      <= s_hrdata;
        hold0_resp_r <= s_hresp;
      end else begin
        pend0_r <= 1'b0;
      end
      if (pend1_r) begin
        pend1_r <= ~(gnt1_s & s_hready);
      end else if (s_hready && own1_s && req1_s && !gnt1_s) begin
        pend1_r      <= 1'b1;
        hold1_r      <= s_hrdata;
        hold1_resp_r <= s_hresp;
      end else begin
        pend1_r <= 1'b0;
      end
    end
  end

endmodule
